dram_cmd_sequencer: RTL and testbench
=====================================

Name: dram_cmd_sequencer

Overview:
- Sits directly downstream of the DRAM address mapper.
- Accepts one decoded request (rank, BG, bank, row, col, read/write) at a time.
- Tracks the open row of every bank and issues the PRE/ACT/RD/WR command sequence to the DRAM PHY command bus.
- Enforces tRP, tRCD, tRAS and tCCD; one request is outstanding at a time.

Parameters:
- RANK_BITS, 1, rank field width (matches dram_pkg)
- BANK_GROUP_BITS, 2, bank-group field width
- BANK_BITS, 2, bank-in-group field width
- ROW_BITS, 15, row field width
- COLUMN_BITS, 10, column field width
- T_RP, 4, PRE to ACT, same bank, cycles (>=1)
- T_RCD, 4, ACT to RD/WR, same bank, cycles (>=1)
- T_RAS, 10, ACT to PRE, same bank, cycles (>=1)
- T_CCD, 2, RD/WR to next accepted request, cycles (>=1)

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous reset, active-high
- req_valid  in  1  decoded request present
- req_ready  out  1  sequencer can accept
- req_write  in  1  1=write, 0=read
- rank  in  RANK_BITS  from address mapper
- BG  in  BANK_GROUP_BITS  from address mapper
- bank  in  BANK_BITS  from address mapper
- row  in  ROW_BITS  from address mapper
- col  in  COLUMN_BITS  from address mapper
- cmd  out  3  0=NOP 1=ACT 2=RD 3=WR 4=PRE
- cmd_rank, cmd_BG, cmd_bank  out  field widths  target of cmd
- cmd_row  out  ROW_BITS  valid with ACT
- cmd_col  out  COLUMN_BITS  valid with RD/WR
- done  out  1  one-cycle pulse in the cycle RD/WR is issued

Behaviour:
- Bank index: idx = {rank, BG, bank}; NB = 2^(RANK_BITS+BANK_GROUP_BITS+BANK_BITS) entries.
- Per entry: open_valid, open_row, ras_cnt (saturating down-counter).
- Reset (async): state IDLE, all open_valid=0, ras_cnt=0, cmd=NOP, req_ready=1, done=0, cmd_* fields=0.
- Handshake:
  - req_ready=1 only in IDLE.
  - Transfer on the rising edge with req_valid&req_ready; all fields latched.
  - Inputs are ignored while req_ready=0; the requester must hold them.
- All outputs are registered. cmd is NOP in every cycle that is not an issue cycle.
- States: IDLE, CHECK, PRE, WAIT_RP, ACT, WAIT_RCD, CAS, WAIT_CCD.
- IDLE: handshake -> CHECK.
- CHECK (one cycle, NOP), lookup on latched idx:
  - open_valid && open_row==row (hit) -> CAS.
  - !open_valid (empty) -> ACT.
  - open_valid && open_row!=row (conflict) -> PRE.
- PRE:
  - Stalls with NOP while ras_cnt[idx]!=0.
  - Then issues PRE and clears open_valid[idx] -> WAIT_RP.
- ACT:
  - Issues ACT with cmd_row, sets open_valid/open_row[idx], loads ras_cnt[idx]=T_RAS-1.
  - -> WAIT_RCD.
- CAS:
  - Issues RD or WR per req_write with cmd_col; done=1.
  - -> WAIT_CCD.
- Timing:
  - A command issued in cycle N is followed by the next command (same request) exactly at N+T_x, with T_x=T_RP after PRE and T_RCD after ACT.
  - Wait states hold for T_x-1 cycles; skip a wait state when T_x==1.
  - After CAS in cycle N, req_ready rises in cycle N+T_CCD.
- ras_cnt of all banks decrements by 1 every cycle until 0, independent of state. A new ACT loads that bank's counter; no other event changes it.
- PRE earliest cycle = ACT cycle + T_RAS (ras_cnt==0 at that cycle).
- Latency from handshake edge A:
  - hit: RD/WR at A+2.
  - empty: ACT A+2, RD/WR A+2+T_RCD.
  - conflict: PRE at max(A+2, lastACT+T_RAS), then ACT, then RD/WR per the timing above.
- cmd_rank/BG/bank carry the latched idx on every non-NOP cycle.
- Reset mid-operation (any state):
  - Request dropped, no done.
  - Table cleared, so the next access to any bank sees empty and issues ACT.
- No refresh, no reordering, no write data path; those belong to other blocks.

Test Plan:
- Reset, then read idx0 row5 col8, accepted at edge A -> cmd NOP at A+1, ACT(row5) at A+2, RD(col8)+done at A+6, req_ready=1 again at A+8.
- Follow-up write idx0 row5 col9 -> hit: WR+done at A'+2, no ACT/PRE issued.
- Read idx0 row7 immediately after the first request's ACT at cycle T -> PRE not before T+10, ACT(row7) at PRE+4, RD at ACT+4.
- Read idx1 row7 while idx0 is open with row5 -> ACT on idx1 without PRE; idx0 stays open (a later row5 read of idx0 hits).
- Assert RST during WAIT_RCD -> next cycle cmd=NOP, done=0, req_ready=1; re-issued read of the same row issues ACT (table cleared).
- Hold req_valid=1 with changing fields while req_ready=0 -> no second transfer; the latched request is unaffected; transfer occurs only on the first cycle req_ready=1.

Source files
------------

// File: rtl/dram_cmd_sequencer.sv
// Tracks the open row of every bank and issues PRE/ACT/RD/WR for one decoded request at a time.
// Latency: hit RD/WR 2 cycles after accept; empty adds ACT + T_RCD; conflict adds a tRAS-gated PRE + T_RP.
// Backpressure: req_ready is high only when idle; it returns T_CCD cycles after the RD/WR is issued.
module dram_cmd_sequencer #(
  parameter int RANK_BITS       = 1,
  parameter int BANK_GROUP_BITS = 2,
  parameter int BANK_BITS       = 2,
  parameter int ROW_BITS        = 15,
  parameter int COLUMN_BITS     = 10,
  parameter int T_RP            = 4,
  parameter int T_RCD           = 4,
  parameter int T_RAS           = 10,
  parameter int T_CCD           = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [RANK_BITS-1:0]       rank,
  input  logic [BANK_GROUP_BITS-1:0] BG,
  input  logic [BANK_BITS-1:0]       bank,
  input  logic [ROW_BITS-1:0]        row,
  input  logic [COLUMN_BITS-1:0]     col,
  output logic [2:0]                 cmd,
  output logic [RANK_BITS-1:0]       cmd_rank,
  output logic [BANK_GROUP_BITS-1:0] cmd_BG,
  output logic [BANK_BITS-1:0]       cmd_bank,
  output logic [ROW_BITS-1:0]        cmd_row,
  output logic [COLUMN_BITS-1:0]     cmd_col,
  output logic                       done
);

  localparam int IDX_BITS = RANK_BITS + BANK_GROUP_BITS + BANK_BITS;
  localparam int NB       = 1 << IDX_BITS;
  localparam int TMAX_A   = (T_RP > T_RCD) ? T_RP : T_RCD;
  localparam int TMAX_B   = (T_RAS > T_CCD) ? T_RAS : T_CCD;
  localparam int TMAX     = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
  localparam int CW       = $clog2(TMAX + 1);

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_CAS, S_WAIT_CCD
  } state_t;

  typedef struct packed {
    logic                   write;
    logic [IDX_BITS-1:0]    idx;
    logic [ROW_BITS-1:0]    row;
    logic [COLUMN_BITS-1:0] col;
  } req_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          wait_q, wait_d;
  req_t                   req_q;
  logic [IDX_BITS-1:0]    cmd_idx_q, idx_d;
  logic [2:0]             cmd_d;
  logic [ROW_BITS-1:0]    row_d;
  logic [COLUMN_BITS-1:0] col_d;
  logic                   done_d;
  logic                   accept, act_fire, pre_fire;

  logic                   open_valid [NB];
  logic [ROW_BITS-1:0]    open_row   [NB];
  logic [CW-1:0]          ras_cnt    [NB];

  assign cmd_rank = cmd_idx_q[IDX_BITS-1 -: RANK_BITS];
  assign cmd_BG   = cmd_idx_q[BANK_BITS +: BANK_GROUP_BITS];
  assign cmd_bank = cmd_idx_q[BANK_BITS-1:0];

  // Next-state and next-output decode; each state's command lands on the bus one cycle later.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    cmd_d    = CMD_NOP;
    done_d   = 1'b0;
    idx_d    = cmd_idx_q;
    row_d    = cmd_row;
    col_d    = cmd_col;
    accept   = 1'b0;
    act_fire = 1'b0;
    pre_fire = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          accept  = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (open_valid[req_q.idx] && open_row[req_q.idx] == req_q.row) state_d = S_CAS;
        else if (!open_valid[req_q.idx])                                state_d = S_ACT;
        else                                                            state_d = S_PRE;
      end
      S_PRE: begin
        // Row must stay open for tRAS after its ACT before it can be closed.
        if (ras_cnt[req_q.idx] == '0) begin
          cmd_d    = CMD_PRE;
          idx_d    = req_q.idx;
          pre_fire = 1'b1;
          if (T_RP > 1) begin
            state_d = S_WAIT_RP;
            wait_d  = CW'(T_RP - 2);
          end else begin
            state_d = S_ACT;
          end
        end
      end
      S_WAIT_RP: begin
        if (wait_q == '0) state_d = S_ACT;
        else              wait_d  = wait_q - CW'(1);
      end
      S_ACT: begin
        cmd_d    = CMD_ACT;
        idx_d    = req_q.idx;
        row_d    = req_q.row;
        act_fire = 1'b1;
        if (T_RCD > 1) begin
          state_d = S_WAIT_RCD;
          wait_d  = CW'(T_RCD - 2);
        end else begin
          state_d = S_CAS;
        end
      end
      S_WAIT_RCD: begin
        if (wait_q == '0) state_d = S_CAS;
        else              wait_d  = wait_q - CW'(1);
      end
      S_CAS: begin
        cmd_d   = req_q.write ? CMD_WR : CMD_RD;
        idx_d   = req_q.idx;
        col_d   = req_q.col;
        done_d  = 1'b1;
        state_d = S_WAIT_CCD;
        wait_d  = CW'(T_CCD - 1);
      end
      S_WAIT_CCD: begin
        // Holds T_CCD cycles so req_ready rises exactly T_CCD after the CAS appears.
        if (wait_q == '0) state_d = S_IDLE;
        else              wait_d  = wait_q - CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, request latch and registered command-bus outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      req_q     <= '0;
      req_ready <= 1'b1;
      cmd       <= CMD_NOP;
      done      <= 1'b0;
      cmd_idx_q <= '0;
      cmd_row   <= '0;
      cmd_col   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      req_ready <= (state_d == S_IDLE);
      cmd       <= cmd_d;
      done      <= done_d;
      cmd_idx_q <= idx_d;
      cmd_row   <= row_d;
      cmd_col   <= col_d;
      if (accept) req_q <= {req_write, rank, BG, bank, row, col};
    end
  end

  // Per-bank open-row table; tRAS counters free-run down to zero and reload only on ACT.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NB; i++) begin
        open_valid[i] <= 1'b0;
        open_row[i]   <= '0;
        ras_cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (act_fire && req_q.idx == IDX_BITS'(i)) begin
          open_valid[i] <= 1'b1;
          open_row[i]   <= req_q.row;
          ras_cnt[i]    <= CW'(T_RAS - 1);
        end else begin
          if (pre_fire && req_q.idx == IDX_BITS'(i)) open_valid[i] <= 1'b0;
          if (ras_cnt[i] != '0) ras_cnt[i] <= ras_cnt[i] - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dram_cmd_sequencer.sv
// Bench for dram_cmd_sequencer: schedule model of expected bus commands plus directed literal checks.
// Latency: model predicts PRE/ACT/RD/WR cycles from the accept edge using the DRAM timing rules.
// Backpressure: model predicts req_ready per cycle; stimulus holds req_valid through busy periods.
module tb_dram_cmd_sequencer;
  localparam int RANK_BITS = 1, BANK_GROUP_BITS = 2, BANK_BITS = 2, ROW_BITS = 15, COLUMN_BITS = 10;
  localparam int T_RP = 4, T_RCD = 4, T_RAS = 10, T_CCD = 2;
  localparam int NB = 32;
  localparam int C_NOP = 0, C_ACT = 1, C_RD = 2, C_WR = 3, C_PRE = 4;

  logic                       CLK = 1'b0;
  logic                       RST = 1'b1;
  logic                       req_valid = 1'b0;
  logic                       req_write = 1'b0;
  logic [RANK_BITS-1:0]       rank = '0;
  logic [BANK_GROUP_BITS-1:0] BG = '0;
  logic [BANK_BITS-1:0]       bank = '0;
  logic [ROW_BITS-1:0]        row = '0;
  logic [COLUMN_BITS-1:0]     col = '0;
  logic                       req_ready;
  logic [2:0]                 cmd;
  logic [RANK_BITS-1:0]       cmd_rank;
  logic [BANK_GROUP_BITS-1:0] cmd_BG;
  logic [BANK_BITS-1:0]       cmd_bank;
  logic [ROW_BITS-1:0]        cmd_row;
  logic [COLUMN_BITS-1:0]     cmd_col;
  logic                       done;

  dram_cmd_sequencer #(
    .RANK_BITS(RANK_BITS), .BANK_GROUP_BITS(BANK_GROUP_BITS), .BANK_BITS(BANK_BITS),
    .ROW_BITS(ROW_BITS), .COLUMN_BITS(COLUMN_BITS),
    .T_RP(T_RP), .T_RCD(T_RCD), .T_RAS(T_RAS), .T_CCD(T_CCD)
  ) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .rank(rank), .BG(BG), .bank(bank), .row(row), .col(col),
    .cmd(cmd), .cmd_rank(cmd_rank), .cmd_BG(cmd_BG), .cmd_bank(cmd_bank),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .done(done)
  );

  always #5 CLK = ~CLK;

  // Cycle k is the interval following rising edge k.
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, got, exp);
    end
  endtask

  // Model: open rows, last ACT cycle per bank, and the command schedule of the current request.
  bit mv    [NB];
  int mrow  [NB];
  int mlast [NB];
  int ready_at = 0;
  int pre_c = -1, act_c = -1, cas_c = -1;
  int cur_idx = 0, cur_row = 0, cur_col = 0;
  bit cur_wr = 1'b0;
  int hs_a = 0, hs_count = 0;
  int exp_cmd, aidx;

  // Compare every cycle against the model, then let the model take a request for the next edge.
  always @(negedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NB; i++) mv[i] = 1'b0;
      ready_at = 0; pre_c = -1; act_c = -1; cas_c = -1;
      chk("reset_fields", 32'({cmd_rank, cmd_BG, cmd_bank, cmd_row, cmd_col}), 32'd0);
    end
    exp_cmd = C_NOP;
    if (cyc == pre_c)      exp_cmd = C_PRE;
    else if (cyc == act_c) exp_cmd = C_ACT;
    else if (cyc == cas_c) exp_cmd = cur_wr ? C_WR : C_RD;
    chk("req_ready", 32'(req_ready), 32'(cyc >= ready_at));
    chk("cmd", 32'(cmd), exp_cmd);
    chk("done", 32'(done), 32'(exp_cmd == C_RD || exp_cmd == C_WR));
    if (exp_cmd != C_NOP) chk("cmd_target", 32'({cmd_rank, cmd_BG, cmd_bank}), cur_idx);
    if (exp_cmd == C_ACT) chk("cmd_row", 32'(cmd_row), cur_row);
    if (exp_cmd == C_RD || exp_cmd == C_WR) chk("cmd_col", 32'(cmd_col), cur_col);
    if (!RST && req_valid && cyc >= ready_at) begin
      aidx    = int'({rank, BG, bank});
      hs_a    = cyc + 1;
      cur_idx = aidx; cur_row = int'(row); cur_col = int'(col); cur_wr = req_write;
      if (mv[aidx] && mrow[aidx] == cur_row) begin
        pre_c = -1; act_c = -1; cas_c = hs_a + 2;
      end else if (!mv[aidx]) begin
        pre_c = -1; act_c = hs_a + 2; cas_c = act_c + T_RCD;
      end else begin
        pre_c = (hs_a + 2 > mlast[aidx] + T_RAS) ? hs_a + 2 : mlast[aidx] + T_RAS;
        act_c = pre_c + T_RP;
        cas_c = act_c + T_RCD;
      end
      if (act_c >= 0) begin
        mv[aidx] = 1'b1; mrow[aidx] = cur_row; mlast[aidx] = act_c;
      end
      ready_at = cas_c + T_CCD;
      hs_count++;
    end
  end

  task automatic send(input bit wr, input int idx, input int r, input int c, output int a);
    int n0, w;
    @(posedge CLK); #2;
    req_write = wr; {rank, BG, bank} = idx[4:0]; row = r[14:0]; col = c[9:0];
    req_valid = 1'b1;
    n0 = hs_count; w = 0;
    while (hs_count == n0 && w < 200) begin
      @(posedge CLK); w++;
    end
    chk("handshake_seen", 32'(hs_count != n0), 32'd1);
    #2 req_valid = 1'b0;
    a = hs_a;
  endtask

  task automatic at_cycle(input int k);
    int g = 0;
    do begin @(negedge CLK); g++; end while (cyc < k && g < 1000);
  endtask

  initial begin
    int a, b, c, n0, w;
    repeat (2) @(posedge CLK);
    #2 RST = 1'b0;

    // Empty bank: ACT then RD after T_RCD, ready again T_CCD after the RD.
    send(1'b0, 0, 5, 8, a);
    at_cycle(a + 1); chk("t1_nop", 32'(cmd), C_NOP);
    at_cycle(a + 2); chk("t1_act", 32'(cmd), C_ACT); chk("t1_act_row", 32'(cmd_row), 5);
    at_cycle(a + 6); chk("t1_rd", 32'(cmd), C_RD); chk("t1_rd_col", 32'(cmd_col), 8);
    chk("t1_done", 32'(done), 1);
    at_cycle(a + 7); chk("t1_busy", 32'(req_ready), 0);
    at_cycle(a + 8); chk("t1_ready", 32'(req_ready), 1);

    // Row hit write.
    send(1'b1, 0, 5, 9, b);
    at_cycle(b + 1); chk("t2_nop", 32'(cmd), C_NOP);
    at_cycle(b + 2); chk("t2_wr", 32'(cmd), C_WR); chk("t2_wr_col", 32'(cmd_col), 9);
    chk("t2_done", 32'(done), 1);

    // Other bank opens without PRE; idx0 stays open and hits.
    send(1'b0, 1, 7, 5, a);
    at_cycle(a + 2); chk("t3_act", 32'(cmd), C_ACT);
    chk("t3_target", 32'({cmd_rank, cmd_BG, cmd_bank}), 1);
    send(1'b0, 0, 5, 6, b);
    at_cycle(b + 2); chk("t3_hit_rd", 32'(cmd), C_RD); chk("t3_hit_col", 32'(cmd_col), 6);

    // Widest field values on the top bank index.
    send(1'b1, 31, 32767, 1023, a);
    at_cycle(a + 2); chk("t4_act_row", 32'(cmd_row), 32767);
    chk("t4_target", 32'({cmd_rank, cmd_BG, cmd_bank}), 31);
    at_cycle(a + 6); chk("t4_wr", 32'(cmd), C_WR); chk("t4_wr_col", 32'(cmd_col), 1023);

    // Conflict right after an ACT: PRE waits for tRAS.
    send(1'b0, 2, 5, 1, a);
    send(1'b0, 2, 7, 2, b);
    chk("t5_accept_edge", b, a + 9);
    at_cycle(a + 11); chk("t5_pre_stall", 32'(cmd), C_NOP);
    at_cycle(a + 12); chk("t5_pre", 32'(cmd), C_PRE);
    at_cycle(a + 16); chk("t5_act", 32'(cmd), C_ACT); chk("t5_act_row", 32'(cmd_row), 7);
    at_cycle(a + 20); chk("t5_rd", 32'(cmd), C_RD); chk("t5_rd_col", 32'(cmd_col), 2);

    // Reset during WAIT_RCD drops the request and clears the table.
    send(1'b0, 3, 9, 2, a);
    at_cycle(a + 2); chk("t6_act", 32'(cmd), C_ACT);
    @(posedge CLK); #2 RST = 1'b1;
    @(negedge CLK);
    chk("t6_rst_cmd", 32'(cmd), C_NOP); chk("t6_rst_done", 32'(done), 0);
    chk("t6_rst_ready", 32'(req_ready), 1);
    @(posedge CLK); #2 RST = 1'b0;
    send(1'b0, 3, 9, 2, b);
    at_cycle(b + 2); chk("t6_react", 32'(cmd), C_ACT);
    at_cycle(b + 6); chk("t6_rd", 32'(cmd), C_RD);
    send(1'b0, 0, 5, 8, c);
    at_cycle(c + 2); chk("t6_idx0_act", 32'(cmd), C_ACT);

    // Changing fields while not ready are ignored; transfer on first ready cycle.
    send(1'b0, 0, 5, 3, a);
    n0 = hs_count; w = 0; req_valid = 1'b1;
    while (hs_count == n0 && w < 100) begin
      if (req_ready) begin
        req_write = 1'b1; {rank, BG, bank} = 5'd0; row = 15'd5; col = 10'd4;
      end else begin
        req_write = 1'($urandom_range(0, 1));
        {rank, BG, bank} = 5'($urandom_range(0, 31));
        row = 15'($urandom); col = 10'($urandom);
      end
      @(posedge CLK); #2; w++;
    end
    req_valid = 1'b0;
    b = hs_a;
    chk("t7_accept_edge", b, a + 5);
    at_cycle(b + 2); chk("t7_wr", 32'(cmd), C_WR); chk("t7_wr_col", 32'(cmd_col), 4);

    repeat (20) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
